// File: rtl/lcd_sequencer.sv
// LCD path control FSM: init, clear, LINE1/LINE2 refresh and setup menu; all outputs registered (1-cycle).
// Optional LCD_E_GEN_EN: LCD_E = registered (STATE != INITIAL_DELAY); otherwise LCD_E is tied low.
`timescale 1ns/1ps
module lcd_sequencer #(
  parameter int unsigned P_INIT_DWELL  = 70,
  parameter int unsigned P_CMD_DWELL   = 30,
  parameter int unsigned P_CLEAR_DWELL = 200,
  parameter int unsigned P_LINE_DWELL  = 20,
  parameter int unsigned P_CHAR_DWELL  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SETUP_REQ,
  input  logic        TIME_SET_REQ,
  input  logic        TZ_SET_REQ,
  input  logic        EXIT_REQ,
  output logic [3:0]  STATE,
  output logic [31:0] CNT,
  output logic [3:0]  CHAR_CNT,
  output logic        LCD_E
);

  typedef enum logic [3:0] {
    S_INITIAL_DELAY = 4'b0000,
    S_FUNCTION_SET  = 4'b0001,
    S_INITIAL_SETUP = 4'b0010,
    S_CLEAR_SCREEN  = 4'b0011,
    S_SETUP         = 4'b0100,
    S_TIME_SET      = 4'b0101,
    S_TZ_SET        = 4'b0110,
    S_LINE1         = 4'b1000,
    S_LINE2         = 4'b1001
  } state_t;

  localparam logic [31:0] L_INIT_LAST  = 32'(P_INIT_DWELL - 1);
  localparam logic [31:0] L_CMD_LAST   = 32'(P_CMD_DWELL - 1);
  localparam logic [31:0] L_CLEAR_LAST = 32'(P_CLEAR_DWELL - 1);
  localparam logic [31:0] L_LINE_LAST  = 32'(P_LINE_DWELL - 1);
  localparam logic [7:0]  L_CHAR_LAST  = 8'(P_CHAR_DWELL - 1);
  localparam logic [3:0]  L_CHAR_MAX   = 4'd7;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_inc;
  logic [3:0]  r_char_cnt;
  logic [3:0]  w_char_nxt;
  logic [7:0]  r_char_div;
  logic [7:0]  w_char_div_nxt;
  logic        r_ret_setup;
  logic        w_ret_setup_nxt;
  logic        r_pending;
  logic        w_pending_nxt;
  logic        w_in_line;
  logic        w_pend_eff;
  logic        w_state_chg;

  // A SETUP_REQ landing on the last LINE2 cycle still counts for that LINE2 exit.
  assign w_in_line  = (r_state == S_LINE1) || (r_state == S_LINE2);
  assign w_pend_eff = r_pending | (SETUP_REQ & w_in_line);
  assign w_cnt_inc  = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_ret_setup_nxt = r_ret_setup;
    w_pending_nxt   = w_pend_eff;
    case (r_state)
      S_INITIAL_DELAY: if (r_cnt == L_INIT_LAST) w_state_nxt = S_FUNCTION_SET;
      S_FUNCTION_SET:  if (r_cnt == L_CMD_LAST)  w_state_nxt = S_INITIAL_SETUP;
      S_INITIAL_SETUP: if (r_cnt == L_CMD_LAST)  w_state_nxt = S_CLEAR_SCREEN;
      S_CLEAR_SCREEN: begin
        if (r_cnt == L_CLEAR_LAST) begin
          w_state_nxt = r_ret_setup ? S_SETUP : S_LINE1;
        end
      end
      S_LINE1: if (r_cnt == L_LINE_LAST) w_state_nxt = S_LINE2;
      S_LINE2: begin
        if (r_cnt == L_LINE_LAST) begin
          if (w_pend_eff) begin
            w_state_nxt     = S_CLEAR_SCREEN;
            w_ret_setup_nxt = 1'b1;
            w_pending_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_LINE1;
          end
        end
      end
      S_SETUP: begin
        if (EXIT_REQ) begin
          w_state_nxt     = S_CLEAR_SCREEN;
          w_ret_setup_nxt = 1'b0;
        end else if (TIME_SET_REQ) begin
          w_state_nxt = S_TIME_SET;
        end else if (TZ_SET_REQ) begin
          w_state_nxt = S_TZ_SET;
        end
      end
      S_TIME_SET, S_TZ_SET: begin
        if (EXIT_REQ) begin
          w_state_nxt     = S_CLEAR_SCREEN;
          w_ret_setup_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_INITIAL_DELAY;
    endcase
  end

  assign w_state_chg = (w_state_nxt != r_state);

  // Character index only advances while staying in SETUP; entry and every other state force 0.
  always_comb begin
    w_char_nxt     = 4'd0;
    w_char_div_nxt = 8'd0;
    if ((w_state_nxt == S_SETUP) && !w_state_chg) begin
      if (r_char_div == L_CHAR_LAST) begin
        w_char_div_nxt = 8'd0;
        w_char_nxt     = (r_char_cnt == L_CHAR_MAX) ? r_char_cnt : r_char_cnt + 4'd1;
      end else begin
        w_char_div_nxt = r_char_div + 8'd1;
        w_char_nxt     = r_char_cnt;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_INITIAL_DELAY;
      r_cnt       <= 32'd0;
      r_char_cnt  <= 4'd0;
      r_char_div  <= 8'd0;
      r_ret_setup <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_state_chg ? 32'd0 : w_cnt_inc;
      r_char_cnt  <= w_char_nxt;
      r_char_div  <= w_char_div_nxt;
      r_ret_setup <= w_ret_setup_nxt;
      r_pending   <= w_pending_nxt;
    end
  end

  assign STATE    = r_state;
  assign CNT      = r_cnt;
  assign CHAR_CNT = r_char_cnt;

`ifdef LCD_E_GEN_EN
  // One cycle late so the strobe lines up with the encoder's registered RS/RW/DATA.
  logic r_lcd_e;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_lcd_e <= 1'b0;
    end else begin
      r_lcd_e <= (r_state != S_INITIAL_DELAY);
    end
  end
  assign LCD_E = r_lcd_e;
`else
  assign LCD_E = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: boundary table, hand-written menu/reset sequences, random requests vs reference model.
`timescale 1ns/1ps
module tb_lcd_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SETUP_REQ = 1'b0;
  logic        TIME_SET_REQ = 1'b0;
  logic        TZ_SET_REQ = 1'b0;
  logic        EXIT_REQ = 1'b0;
  logic [3:0]  STATE;
  logic [31:0] CNT;
  logic [3:0]  CHAR_CNT;
  logic        LCD_E;

  lcd_sequencer dut (
    .CLK(CLK), .RESET(RESET), .SETUP_REQ(SETUP_REQ), .TIME_SET_REQ(TIME_SET_REQ),
    .TZ_SET_REQ(TZ_SET_REQ), .EXIT_REQ(EXIT_REQ), .STATE(STATE), .CNT(CNT),
    .CHAR_CNT(CHAR_CNT), .LCD_E(LCD_E)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  // Reference model: state code, cycles in state, menu flags.
  int              m_state;
  longint unsigned m_cnt;
  int              m_char;
  bit              m_ret, m_pend, m_lcde;

  typedef struct {
    int          cyc;
    logic [3:0]  st;
    logic [31:0] cnt;
  } vec_t;
  vec_t vecs[10];

  function automatic int dwell_of(input int s);
    case (s)
      0: return 70;
      1, 2: return 30;
      3: return 200;
      8, 9: return 20;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_char = 0; m_ret = 0; m_pend = 0; m_lcde = 0;
  endtask

  task automatic model_step(input bit sreq, input bit treq, input bit zreq, input bit ereq);
    int nxt;
    bit timed;
`ifdef LCD_E_GEN_EN
    m_lcde = (m_state != 0);
`else
    m_lcde = 0;
`endif
    if ((m_state == 8 || m_state == 9) && sreq) m_pend = 1;
    timed = (dwell_of(m_state) != 0) && (m_cnt == longint'(dwell_of(m_state) - 1));
    nxt = m_state;
    if (timed) begin
      case (m_state)
        0: nxt = 1;
        1: nxt = 2;
        2: nxt = 3;
        3: nxt = m_ret ? 4 : 8;
        8: nxt = 9;
        default: begin
          if (m_pend) begin nxt = 3; m_ret = 1; m_pend = 0; end
          else nxt = 8;
        end
      endcase
    end else if (m_state == 4) begin
      if (ereq) begin nxt = 3; m_ret = 0; end
      else if (treq) nxt = 5;
      else if (zreq) nxt = 6;
    end else if ((m_state == 5 || m_state == 6) && ereq) begin
      nxt = 3; m_ret = 1;
    end
    if (nxt != m_state) m_cnt = 0;
    else if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_state = nxt;
    m_char = (m_state == 4) ? ((m_cnt / 4 > 7) ? 7 : int'(m_cnt / 4)) : 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s k=%0d actual=%0d required=%0d", name, k, act, exp);
    end
  endtask

  task automatic check_model();
    n_checks++;
    if (STATE !== m_state[3:0] || CNT !== m_cnt[31:0] || CHAR_CNT !== m_char[3:0] || LCD_E !== m_lcde) begin
      n_errors++;
      $display("FAIL model k=%0d state %h req %h cnt %0d req %0d char %0d req %0d lcd_e %b req %b",
               k, STATE, m_state[3:0], CNT, m_cnt[31:0], CHAR_CNT, m_char[3:0], LCD_E, m_lcde);
    end
  endtask

  // One rising edge: pulses driven by the caller are seen by this edge only.
  task automatic tick();
    bit s, t, z, e;
    s = SETUP_REQ; t = TIME_SET_REQ; z = TZ_SET_REQ; e = EXIT_REQ;
    @(posedge CLK);
    #1;
    k++;
    model_step(s, t, z, e);
    check_model();
    SETUP_REQ = 0; TIME_SET_REQ = 0; TZ_SET_REQ = 0; EXIT_REQ = 0;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  bit exp_e;

  initial begin
    vecs[0] = '{0,   4'h0, 0};   vecs[1] = '{69,  4'h0, 69};
    vecs[2] = '{70,  4'h1, 0};   vecs[3] = '{99,  4'h1, 29};
    vecs[4] = '{100, 4'h2, 0};   vecs[5] = '{130, 4'h3, 0};
    vecs[6] = '{329, 4'h3, 199}; vecs[7] = '{330, 4'h8, 0};
    vecs[8] = '{350, 4'h9, 0};   vecs[9] = '{370, 4'h8, 0};

    // Reset state while RESET is held.
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_state", 32'(STATE), 0);
    chk("rst_cnt", CNT, 0);
    chk("rst_char", 32'(CHAR_CNT), 0);
    chk("rst_lcd_e", 32'(LCD_E), 0);
    @(negedge CLK);
    RESET = 0;
    model_reset();
    k = 0;

    foreach (vecs[i]) begin
      run_to(vecs[i].cyc);
      chk("tbl_state", 32'(STATE), 32'(vecs[i].st));
      chk("tbl_cnt", CNT, vecs[i].cnt);
    end

    // Setup entry requested mid-LINE1: LINE1, full LINE2, CLEAR, SETUP.
    run_to(375);
    chk("line1_cnt5", CNT, 5);
    SETUP_REQ = 1;
    tick();
    run_to(389); chk("l1_hold", 32'(STATE), 8);
    run_to(390); chk("l2_enter", 32'(STATE), 9);
    run_to(409); chk("l2_full", 32'(STATE), 9);
    run_to(410); chk("clr_enter", 32'(STATE), 3);
    run_to(609); chk("clr_full", 32'(STATE), 3);
    run_to(610); chk("setup_enter", 32'(STATE), 4);
    for (int j = 0; j < 40; j++) begin
      run_to(610 + j);
      chk("char_step", 32'(CHAR_CNT), (j / 4 > 7) ? 7 : j / 4);
    end

    // TIME_SET beats TZ_SET; other pulses ignored in TIME_SET; EXIT returns to menu.
    TIME_SET_REQ = 1; TZ_SET_REQ = 1;
    tick();
    chk("prio_time", 32'(STATE), 5);
    TZ_SET_REQ = 1; tick();
    SETUP_REQ = 1; tick();
    chk("time_hold", 32'(STATE), 5);
    EXIT_REQ = 1; tick();
    chk("time_exit", 32'(STATE), 3);
    run_to(k + 200);
    chk("back_setup", 32'(STATE), 4);
    chk("back_char", 32'(CHAR_CNT), 0);

    // EXIT beats TIME_SET; leaves to LINE1.
    EXIT_REQ = 1; TIME_SET_REQ = 1;
    tick();
    chk("prio_exit", 32'(STATE), 3);
    run_to(k + 200);
    chk("exit_line1", 32'(STATE), 8);

    // Reach TZ_SET, then async reset between edges.
    SETUP_REQ = 1;
    tick();
    for (int n = 0; n < 1000 && STATE != 4'h4; n++) tick();
    chk("reach_setup", 32'(STATE), 4);
    TZ_SET_REQ = 1;
    tick();
    chk("tz_enter", 32'(STATE), 6);
    repeat (7) tick();
    @(posedge CLK);
    #3;
    RESET = 1;
    #1;
    chk("arst_state", 32'(STATE), 0);
    chk("arst_cnt", CNT, 0);
    chk("arst_char", 32'(CHAR_CNT), 0);
    chk("arst_lcd_e", 32'(LCD_E), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
    model_reset();
    k = 0;
`ifdef LCD_E_GEN_EN
    exp_e = 1;
`else
    exp_e = 0;
`endif
    run_to(69); chk("e_init", 32'(LCD_E), 0);
    run_to(70); chk("fs_state", 32'(STATE), 1); chk("e_fs_first", 32'(LCD_E), 0);
    run_to(71); chk("e_rise", 32'(LCD_E), 32'(exp_e));
    run_to(330); chk("reinit_line1", 32'(STATE), 8); chk("e_hold", 32'(LCD_E), 32'(exp_e));

    // Random request pulses against the model.
    for (int n = 0; n < 6000; n++) begin
      SETUP_REQ    = ($urandom_range(0, 15) == 0);
      TIME_SET_REQ = ($urandom_range(0, 15) == 0);
      TZ_SET_REQ   = ($urandom_range(0, 15) == 0);
      EXIT_REQ     = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Upstream control FSM for the LCD path. Generates STATE, CNT and CHAR_CNT, which drive the registered LCD command/data encoder.
- Sequences power-up init, screen clear, the continuous LINE1/LINE2 refresh loop and the setup menu (SETUP, TIME_SET, TZ_SET), driven by user request pulses.

Parameters:
- P_INIT_DWELL, 70: cycles spent in INITIAL_DELAY.
- P_CMD_DWELL, 30: cycles in FUNCTION_SET and in INITIAL_SETUP.
- P_CLEAR_DWELL, 200: cycles in CLEAR_SCREEN.
- P_LINE_DWELL, 20: cycles in LINE1 and in LINE2. Must be ≥ 10.
- P_CHAR_DWELL, 4: cycles per CHAR_CNT step in SETUP.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SETUP_REQ  in  1  one-cycle pulse: enter setup menu.
- TIME_SET_REQ  in  1  one-cycle pulse: enter time-set from SETUP.
- TZ_SET_REQ  in  1  one-cycle pulse: enter timezone-set from SETUP.
- EXIT_REQ  in  1  one-cycle pulse: leave SETUP, TIME_SET or TZ_SET.
- STATE  out  4  current state code.
- CNT  out  32  cycles elapsed in the current state, starting at 0.
- CHAR_CNT  out  4  setup-screen character index.
- LCD_E  out  1  LCD enable strobe (see Optional Feature).

Behaviour:
- State codes: INITIAL_DELAY=0000, FUNCTION_SET=0001, INITIAL_SETUP=0010, CLEAR_SCREEN=0011, SETUP=0100, TIME_SET=0101, TZ_SET=0110, LINE1=1000, LINE2=1001. No other code is ever driven.
- Reset: STATE=INITIAL_DELAY, CNT=0, CHAR_CNT=0, LCD_E=0, internal RET_SETUP flag=0, pending-setup flag=0.
- Reset is honoured mid-operation in any state and immediately returns everything to reset values.
- All outputs are registered. STATE, CNT and CHAR_CNT change only on rising CLK.
- CNT increments every cycle within a state. On every state change, CNT is 0 in the first cycle of the new state. CNT never wraps in practice; it saturates at 2^32-1.
- Timed transitions occur in the cycle where CNT == dwell-1, so the state lasts exactly "dwell" cycles:
  - INITIAL_DELAY → FUNCTION_SET after P_INIT_DWELL.
  - FUNCTION_SET → INITIAL_SETUP after P_CMD_DWELL.
  - INITIAL_SETUP → CLEAR_SCREEN after P_CMD_DWELL.
  - CLEAR_SCREEN → SETUP if RET_SETUP=1, else LINE1, after P_CLEAR_DWELL.
  - LINE1 → LINE2 after P_LINE_DWELL.
  - LINE2 → LINE1 after P_LINE_DWELL, unless pending-setup=1.
- Setup entry:
  - A SETUP_REQ pulse in LINE1 or LINE2 sets pending-setup. The request is latched, never lost.
  - At the end of LINE2 with pending-setup=1: go to CLEAR_SCREEN, set RET_SETUP=1, clear pending-setup.
  - SETUP_REQ in any other state is ignored.
- SETUP state:
  - No timeout.
  - CHAR_CNT=0 on entry, then increments every P_CHAR_DWELL cycles and saturates at 7.
  - TIME_SET_REQ → TIME_SET. TZ_SET_REQ → TZ_SET. EXIT_REQ → CLEAR_SCREEN with RET_SETUP=0.
  - Simultaneous requests: priority is EXIT_REQ > TIME_SET_REQ > TZ_SET_REQ.
- TIME_SET and TZ_SET:
  - Held until EXIT_REQ, then → CLEAR_SCREEN with RET_SETUP=1 (returns to the SETUP menu).
  - Other request pulses are ignored.
- CHAR_CNT is 0 in every state except SETUP.
- Request pulses are sampled only on the rising edge. A pulse in the same cycle as a timed transition is evaluated against the pre-transition state.

Optional Feature:
- Macro LCD_E_GEN_EN.
- Defined:
  - LCD_E is a registered copy of "STATE != INITIAL_DELAY", delayed one cycle. This aligns it with the one-cycle-registered RS/RW/DATA of the downstream encoder.
  - LCD_E = 0 during reset, during INITIAL_DELAY, and in the first cycle of FUNCTION_SET.
- Undefined: LCD_E is tied to 0 and an external strobe generator is used.

Test Plan:
- Reset release, no requests → STATE 0000 for 70 cycles, 0001 for 30, 0010 for 30, 0011 for 200, then 1000/1001 alternating every 20 cycles. CNT is 0 at each state change.
- SETUP_REQ pulsed at LINE1 CNT=5 → LINE1 finishes, LINE2 runs its full 20 cycles, then CLEAR_SCREEN (200 cycles), then SETUP. CHAR_CNT reads 0,1,…,7 at 4-cycle steps and holds at 7.
- In SETUP, TIME_SET_REQ and TZ_SET_REQ asserted in the same cycle → STATE=0101. Then EXIT_REQ → CLEAR_SCREEN → SETUP (0100).
- In SETUP, EXIT_REQ and TIME_SET_REQ asserted in the same cycle → CLEAR_SCREEN, then LINE1. TIME_SET is never entered.
- RESET asserted asynchronously mid-TZ_SET, between clock edges → STATE=0000, CNT=0, CHAR_CNT=0 and LCD_E=0 immediately. Init sequence restarts after release.
- With LCD_E_GEN_EN defined → LCD_E rises exactly 71 cycles after reset release and stays 1. Without the macro → LCD_E stays 0 throughout.
